// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state encodings, opcodes and control codes shared by the control path
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_ALUWB,
        S_EXECI,
        S_JAL,
        S_BEQ,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// imm_src_decoder: selects the immediate format from the opcode; R-type and unknown ops fall back to I-type
module imm_src_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] ImmSrc
);

    // opcode to immediate format
    always_comb begin
        ImmSrc = op == OP_SW  ? IMM_S :
                 op == OP_BEQ ? IMM_B :
                 op == OP_JAL ? IMM_J : IMM_I;
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main sequencer of the multi-cycle RV32I core with memory handshake, trap and retire counter
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       ImmSrc,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    state_t state, state_nx;
    logic   retire;

    imm_src_decoder u_imm (
        .op     (op),
        .ImmSrc (ImmSrc)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    // retired-instruction counter; an abandoned instruction never retires because reset wins
    always_ff @(posedge clk) begin
        if (reset)       InstrCount <= '0;
        else if (retire) InstrCount <= InstrCount + CNT_W'(1);
    end

    // next state and retire condition
    always_comb begin
        state_nx = S_TRAP;
        retire   = 1'b0;
        case (state)
            S_FETCH:    state_nx = MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   state_nx = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                   op == OP_R   ? S_EXECR :
                                   op == OP_I   ? S_EXECI :
                                   op == OP_JAL ? S_JAL   :
                                   op == OP_BEQ ? S_BEQ   : S_TRAP;
            S_MEMADR:   state_nx = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nx = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: begin
                state_nx = MemReady ? S_FETCH : S_MEMWRITE;
                retire   = MemReady;
            end
            S_EXECR, S_EXECI, S_JAL: state_nx = S_ALUWB;
            S_ALUWB, S_MEMWB, S_BEQ: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default:    state_nx = S_TRAP;
        endcase
    end

    // Moore output decode; write strobes are suppressed while reset is held
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUop     = ALUOP_ADD;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUop   = ALUOP_FUNC;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUop   = ALUOP_FUNC;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUop   = ALUOP_SUB;
                PCWrite = Zero;
            end
            S_TRAP:     Illegal = 1'b1;
            default:    Illegal = 1'b0;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction streams checked against a per-instruction phase model
module tb_multicycle_control_fsm;

    localparam logic [6:0] L_LW  = 7'b0000011;
    localparam logic [6:0] L_SW  = 7'b0100011;
    localparam logic [6:0] L_R   = 7'b0110011;
    localparam logic [6:0] L_I   = 7'b0010011;
    localparam logic [6:0] L_JAL = 7'b1101111;
    localparam logic [6:0] L_BEQ = 7'b1100011;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECR, P_ALUWB, P_EXECI, P_JAL, P_BEQ, P_TRAP} phase_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = L_R;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;

    logic        a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
    logic [1:0]  a_rs, a_sa, a_sb, a_ao, a_imm;
    logic [31:0] a_cnt;
    logic        b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
    logic [1:0]  b_rs, b_sa, b_sb, b_ao, b_imm;
    logic [3:0]  b_cnt;
    logic [15:0] a_vec, b_vec;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt = 0;
    int          idx, rst_at;
    bit          done;

    assign a_vec = {a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_ao, a_imm, a_ill};
    assign b_vec = {b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_ao, b_imm, b_ill};

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw), .RegWrite(a_rw),
        .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUop(a_ao), .ImmSrc(a_imm),
        .Illegal(a_ill), .InstrCount(a_cnt)
    );

    multicycle_control_fsm #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw), .RegWrite(b_rw),
        .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUop(b_ao), .ImmSrc(b_imm),
        .Illegal(b_ill), .InstrCount(b_cnt)
    );

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            L_SW:    return 2'b01;
            L_BEQ:   return 2'b10;
            L_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] expect_out(input phase_t ph, input logic mr, input logic z,
                                               input logic rst, input logic [6:0] o);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, ao;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sb, ao} = '0;
        case (ph)
            P_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            P_MEMREAD:  adr = 1'b1;
            P_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            P_EXECR:    begin sa = 2'b10; ao = 2'b10; end
            P_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            P_ALUWB:    rw = 1'b1;
            P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            P_BEQ:      begin sa = 2'b10; ao = 2'b01; pcw = z; end
            default:    ill = 1'b1;
        endcase
        if (rst) {pcw, irw, mw, rw} = '0;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, imm_of(o), ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input phase_t ph, input logic mr_i, input logic z_i);
        logic r, mr;
        logic [15:0] e;
        if (done) return;
        r  = (idx == rst_at);
        mr = (ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) ? mr_i : ($urandom_range(0, 1) != 0);
        reset    = r;
        MemReady = mr;
        Zero     = z_i;
        #3;
        e = expect_out(ph, mr, z_i, r, op);
        chk($sformatf("outputs_%s", ph.name()), {16'b0, a_vec}, {16'b0, e});
        chk($sformatf("outputs4_%s", ph.name()), {16'b0, b_vec}, {16'b0, e});
        chk("instr_count", a_cnt, cnt);
        chk("instr_count4", {28'b0, b_cnt}, cnt & 32'hf);
        @(posedge clk);
        #1;
        if (r) begin
            cnt  = 0;
            done = 1;
        end else if (ph inside {P_ALUWB, P_MEMWB, P_BEQ} || (ph == P_MEMWRITE && mr)) begin
            cnt = cnt + 1;
        end
        idx++;
    endtask

    task automatic handshake(input phase_t ph, input int n);
        repeat (n) step(ph, 1'b0, $urandom_range(0, 1) != 0);
        step(ph, 1'b1, $urandom_range(0, 1) != 0);
    endtask

    task automatic run_instr(input logic [6:0] o, input int sf, input int sm, input int ra, input logic z);
        op     = o;
        idx    = 0;
        rst_at = ra;
        done   = 0;
        handshake(P_FETCH, sf);
        step(P_DECODE, 1'b0, $urandom_range(0, 1) != 0);
        case (o)
            L_LW:  begin step(P_MEMADR, 1'b0, 1'b0); handshake(P_MEMREAD, sm); step(P_MEMWB, 1'b0, 1'b0); end
            L_SW:  begin step(P_MEMADR, 1'b0, 1'b0); handshake(P_MEMWRITE, sm); end
            L_R:   begin step(P_EXECR, 1'b0, 1'b0); step(P_ALUWB, 1'b0, 1'b0); end
            L_I:   begin step(P_EXECI, 1'b0, 1'b0); step(P_ALUWB, 1'b0, 1'b0); end
            L_JAL: begin step(P_JAL, 1'b0, 1'b0); step(P_ALUWB, 1'b0, 1'b0); end
            L_BEQ: step(P_BEQ, 1'b0, z);
            default: begin
                repeat (sm + 10) step(P_TRAP, 1'b0, $urandom_range(0, 1) != 0);
                if (!done) rst_at = idx;
                step(P_TRAP, 1'b0, 1'b0);
            end
        endcase
    endtask

    initial begin
        logic [6:0] o;
        int k;
        @(posedge clk);
        #1;
        repeat (2) begin
            idx = 0; rst_at = 0; done = 0;
            step(P_FETCH, 1'b1, 1'b0);
        end
        run_instr(L_R, 0, 0, -1, 1'b0);
        chk("add_retired", a_cnt, 32'd1);
        run_instr(L_LW, 0, 2, -1, 1'b0);
        chk("lw_retired", a_cnt, 32'd2);
        run_instr(L_BEQ, 0, 0, -1, 1'b1);
        run_instr(L_BEQ, 0, 0, -1, 1'b0);
        chk("beq_retired", a_cnt, 32'd4);
        run_instr(L_SW, 0, 3, -1, 1'b0);
        chk("sw_retired", a_cnt, 32'd5);
        run_instr(L_SW, 0, 3, 4, 1'b0);
        chk("sw_reset_abandoned", a_cnt, 32'd0);
        run_instr(L_JAL, 1, 0, -1, 1'b0);
        chk("jal_retired", a_cnt, 32'd1);
        run_instr(7'b1111111, 0, 0, -1, 1'b0);
        chk("trap_reset_count", a_cnt, 32'd0);
        repeat (16) run_instr(L_I, 0, 0, -1, 1'b0);
        chk("addi16_count32", a_cnt, 32'd16);
        chk("addi16_count4_wrap", {28'b0, b_cnt}, 32'd0);
        repeat (400) begin
            k = $urandom_range(0, 19);
            o = k < 4  ? L_LW  :
                k < 7  ? L_SW  :
                k < 10 ? L_R   :
                k < 13 ? L_I   :
                k < 15 ? L_JAL :
                k < 19 ? L_BEQ :
                (k[0] ? 7'b0010111 : 7'b0000000);
            run_instr(o, $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1,
                      $urandom_range(0, 1) != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
